// File: rtl/wide_add_seq.sv
// Multi-word add/subtract sequencer: one shared 16-bit adder processes an
// N = 16*WORDS bit operation one limb per cycle, LSB limb first.

module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   result,
  output logic                  carry,
  output logic                  overflow
);

  localparam int N  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic          cin_reg;

  logic [15:0]   a_limb;
  logic [15:0]   b_limb;
  logic [15:0]   sum_limb;
  logic          carry_limb;

  assign a_limb = a_reg[16*idx +: 16];
  assign b_limb = b_reg[16*idx +: 16];

  adder16 u_adder (
    .a     (a_limb),
    .b     (b_limb),
    .cin   (cin_reg),
    .sum   (sum_limb),
    .carry (carry_limb)
  );

  // Subtraction is a + ~b + 1: b is inverted at capture and the +1 enters
  // as the initial carry-in, so the same adder path serves both operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      cin_reg  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= sub ? ~b : b;
            cin_reg <= sub;
            result  <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          result[16*idx +: 16] <= sum_limb;
          cin_reg              <= carry_limb;
          idx                  <= idx + IW'(1);
          // Signed overflow is judged on the top limb only: same-sign inputs
          // producing a result of the opposite sign.
          if (idx == LAST_IDX) begin
            carry    <= carry_limb;
            overflow <= (a_limb[15] == b_limb[15]) && (sum_limb[15] != a_limb[15]);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (WORDS=4): directed corner cases plus
// randomized add/sub checked against a whole-word arithmetic reference model.

module tb_wide_add_seq;

  localparam int WORDS = 4;
  localparam int N     = 16 * WORDS;
  localparam int LIMIT = 4 * WORDS + 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         carry;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width arithmetic; carry for subtract means a >= b unsigned.
  function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic msub,
                                output logic [N-1:0] r, output logic c, output logic v);
    logic [N:0] full;
    if (!msub) begin
      full = {1'b0, ma} + {1'b0, mb};
      r    = full[N-1:0];
      c    = full[N];
      v    = (ma[N-1] == mb[N-1]) && (r[N-1] != ma[N-1]);
    end else begin
      r = ma - mb;
      c = (ma >= mb);
      v = (ma[N-1] != mb[N-1]) && (r[N-1] != ma[N-1]);
    end
  endfunction

  // Issues one operation and waits (bounded) for done; reports timing only.
  task automatic do_op(input logic [N-1:0] oa, input logic [N-1:0] ob, input logic osub,
                       output int edges, output int busy_cyc);
    a = oa; b = ob; sub = osub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    busy_cyc = 0;
    while (!done && edges < LIMIT) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    int edges, bc;
    logic [N-1:0] er; logic ec, ev;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, result, carry, overflow} !== {1'b0, 1'b0, {N{1'b0}}, 1'b0, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b result=%h carry=%b ovf=%b, expected all zero",
               busy, done, result, carry, overflow);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    do_op('0, '0, 1'b0, edges, bc);
    model('0, '0, 1'b0, er, ec, ev);
    n_cmp++;
    if (edges !== WORDS) begin
      n_bad++;
      $display("[TB] FAIL zero_latency: got %0d edges, expected %0d", edges, WORDS);
    end
    n_cmp++;
    if (bc !== WORDS) begin
      n_bad++;
      $display("[TB] FAIL zero_busy_cycles: got %0d, expected %0d", bc, WORDS);
    end
    n_cmp++;
    if ({result, carry, overflow} !== {er, ec, ev}) begin
      n_bad++;
      $display("[TB] FAIL zero_op: got %h c=%b v=%b, expected %h c=%b v=%b", result, carry, overflow, er, ec, ev);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] va [5];
    logic [N-1:0] vb [5];
    logic         vs [5];
    logic [N-1:0] er; logic ec, ev;
    int edges, bc;
    va[0] = 64'h0000_FFFF_FFFF_0001; vb[0] = 64'h0000_0000_0000_FFFF; vs[0] = 1'b0;
    va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h1;                   vs[1] = 1'b0;
    va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'h1;                   vs[2] = 1'b0;
    va[3] = 64'h0;                   vb[3] = 64'h1;                   vs[3] = 1'b1;
    va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'h1;                   vs[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vs[i], edges, bc);
      model(va[i], vb[i], vs[i], er, ec, ev);
      n_cmp++;
      if (edges !== WORDS || {result, carry, overflow} !== {er, ec, ev}) begin
        n_bad++;
        $display("[TB] FAIL directed_%0d: got %h c=%b v=%b after %0d edges, expected %h c=%b v=%b after %0d",
                 i, result, carry, overflow, edges, er, ec, ev, WORDS);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] ra, rb, er; logic rs, ec, ev;
    int edges, bc;
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, edges, bc);
      model(ra, rb, rs, er, ec, ev);
      n_cmp++;
      if (edges !== WORDS || {result, carry, overflow} !== {er, ec, ev}) begin
        n_bad++;
        $display("[TB] FAIL random_%0d: a=%h b=%h sub=%b got %h c=%b v=%b, expected %h c=%b v=%b",
                 i, ra, rb, rs, result, carry, overflow, er, ec, ev);
      end
    end
    // Result, carry and overflow must stay put while idle.
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if ({result, carry, overflow, done} !== {er, ec, ev, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL idle_hold: got %h c=%b v=%b done=%b, expected %h c=%b v=%b done=0",
               result, carry, overflow, done, er, ec, ev);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a1, b1, a2, b2, er; logic s1, s2, ec, ev;
    int edges;
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; s1 = 1'b1;
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; s2 = 1'b0;
    a = a1; b = b1; sub = s1; start = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    while (!done && edges < LIMIT) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      edges++;
    end
    model(a1, b1, s1, er, ec, ev);
    n_cmp++;
    if (edges !== WORDS || {result, carry, overflow} !== {er, ec, ev}) begin
      n_bad++;
      $display("[TB] FAIL held_start_op1: got %h c=%b v=%b after %0d edges, expected %h c=%b v=%b after %0d",
               result, carry, overflow, edges, er, ec, ev, WORDS);
    end
    a = a2; b = b2; sub = s2;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL done_cycle_accept: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    n_cmp++;
    if ({carry, overflow} !== {ec, ev}) begin
      n_bad++;
      $display("[TB] FAIL flags_hold_in_run: got c=%b v=%b, expected c=%b v=%b", carry, overflow, ec, ev);
    end
    edges = 0;
    while (!done && edges < LIMIT) begin
      @(posedge clk); #1;
      edges++;
    end
    model(a2, b2, s2, er, ec, ev);
    n_cmp++;
    if (edges !== WORDS || {result, carry, overflow} !== {er, ec, ev}) begin
      n_bad++;
      $display("[TB] FAIL back_to_back_op2: got %h c=%b v=%b after %0d edges, expected %h c=%b v=%b after %0d",
               result, carry, overflow, edges, er, ec, ev, WORDS);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL done_one_cycle: got done=%b, expected 0", done);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] er; logic ec, ev;
    int edges, bc, pulses;
    do_op({N{1'b1}}, 64'h1, 1'b0, edges, bc);
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, result, carry, overflow} !== {1'b0, 1'b0, {N{1'b0}}, 1'b0, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL mid_run_reset: got busy=%b done=%b result=%h c=%b v=%b, expected all zero",
               busy, done, result, carry, overflow);
    end
    pulses = 0;
    for (int i = 0; i < 2 * WORDS; i++) begin
      if (done || busy) pulses++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("[TB] FAIL abort_no_done: got %0d busy/done cycles, expected 0", pulses);
    end
    do_op(64'h1, 64'h2, 1'b0, edges, bc);
    model(64'h1, 64'h2, 1'b0, er, ec, ev);
    n_cmp++;
    if (edges !== WORDS || {result, carry, overflow} !== {er, ec, ev}) begin
      n_bad++;
      $display("[TB] FAIL after_reset_op: got %h c=%b v=%b, expected %h c=%b v=%b",
               result, carry, overflow, er, ec, ev);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
